spi_slave: RTL and testbench

//  SPI target-side peripheral; counterpart of the SoC's SPI master. An external master drives sclk/nss/mosi.

---
 rtl/spi_slave_if.sv | 15 +
 rtl/spi_slave.sv | 264 ++++++++++++++++++++++++++
 tb/tb_spi_slave.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// APB slave-side bundle shared by the SPI peripherals on the peripheral bus.
`timescale 1ns/1ps
interface apb_intf;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
endinterface

// File: rtl/spi_slave.sv
// SPI target peripheral: synchronized sclk/nss/mosi, 8/16-bit frames in all four
// CPOL/CPHA modes, APB register file (CR1/CR2/SR/DR) and a level interrupt.
`timescale 1ns/1ps
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic   clk,
  input  logic   rstn,
  apb_intf.slave s_apb_intf,
  input  logic   sclk,
  input  logic   nss,
  input  logic   mosi,
  output logic   miso,
  output logic   miso_oe,
  output logic   irq_out
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t state_r, next_state_s;

  logic [SYNC_STAGES-1:0] sclk_sync_r, nss_sync_r, mosi_sync_r;
  logic        sclk_s, nss_s, mosi_s, sclk_d_r, nss_d_r;
  logic        cpha_r, cpol_r, spe_r, lsbf_r, dff_r;
  logic        errie_r, rxneie_r, txeie_r;
  logic        txe_r, rxne_r, udr_r, ovr_r, udr_pend_r;
  logic [15:0] tx_buff_r, rx_buff_r, tx_sft_r, rx_sft_r;
  logic [3:0]  bit_cnt_r;
  logic        done_r, first_r, miso_r, miso_oe_r;
  logic [31:0] prdata_r;

  logic        sclk_rise_s, sclk_fall_s, lead_s, trail_s, sample_s, drive_s;
  logic        nss_fall_s, nss_rise_s, start_s, run_s;
  logic        smp_s, complete_s, b2b_s, load_s, drv_s;
  logic [3:0]  last_s;
  logic [15:0] tx_load_s, tx_shift_s, rx_next_s, rx_word_s;
  logic        setup_s, wr_s, rd_s, cr1_wr_s, cr2_wr_s, sr_wr_s, dr_wr_s, dr_rd_s;
  logic        rx_store_s, ovr_set_s, udr_set_s, bsy_s;
  logic        unused_s;

  function automatic logic pick_bit(input logic [15:0] v, input logic lsb, input logic wide);
    if (lsb)       pick_bit = v[0];
    else if (wide) pick_bit = v[15];
    else           pick_bit = v[7];
  endfunction

  assign setup_s  = s_apb_intf.psel & ~s_apb_intf.penable;
  assign wr_s     = setup_s & s_apb_intf.pwrite;
  assign rd_s     = setup_s & ~s_apb_intf.pwrite;
  assign cr1_wr_s = wr_s & (s_apb_intf.paddr == 12'h000);
  assign cr2_wr_s = wr_s & (s_apb_intf.paddr == 12'h004);
  assign sr_wr_s  = wr_s & (s_apb_intf.paddr == 12'h008);
  assign dr_wr_s  = wr_s & (s_apb_intf.paddr == 12'h00C);
  assign dr_rd_s  = rd_s & (s_apb_intf.paddr == 12'h00C);
  assign unused_s = ^s_apb_intf.pwdata[31:16];

  assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
  assign nss_s  = nss_sync_r[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

  assign sclk_rise_s = sclk_s & ~sclk_d_r;
  assign sclk_fall_s = ~sclk_s & sclk_d_r;
  assign lead_s      = cpol_r ? sclk_fall_s : sclk_rise_s;
  assign trail_s     = cpol_r ? sclk_rise_s : sclk_fall_s;
  assign sample_s    = cpha_r ? trail_s : lead_s;
  assign drive_s     = cpha_r ? lead_s : trail_s;
  assign nss_fall_s  = ~nss_s & nss_d_r;
  assign nss_rise_s  = nss_s & ~nss_d_r;
  assign last_s      = dff_r ? 4'd15 : 4'd7;
  assign bsy_s       = ~nss_s & spe_r;

  // Back-to-back reload happens on the trailing edge that ends the last bit.
  assign smp_s      = run_s & sample_s;
  assign complete_s = smp_s & (bit_cnt_r == last_s);
  assign b2b_s      = run_s & trail_s & (cpha_r ? (bit_cnt_r == last_s) : done_r);
  assign load_s     = start_s | b2b_s;
  assign drv_s      = run_s & drive_s & ~b2b_s;

  assign tx_load_s  = txe_r ? 16'h0000 : (dff_r ? tx_buff_r : {8'h00, tx_buff_r[7:0]});
  assign tx_shift_s = lsbf_r ? {1'b0, tx_sft_r[15:1]} : {tx_sft_r[14:0], 1'b0};
  assign rx_next_s  = lsbf_r ? (dff_r ? {mosi_s, rx_sft_r[15:1]} : {8'h00, mosi_s, rx_sft_r[7:1]})
                             : {rx_sft_r[14:0], mosi_s};
  assign rx_word_s  = dff_r ? rx_next_s : {8'h00, rx_next_s[7:0]};

  // A DR read in the completion cycle frees the buffer for the new frame.
  assign rx_store_s = complete_s & (~rxne_r | dr_rd_s);
  assign ovr_set_s  = complete_s & rxne_r & ~dr_rd_s;
  assign udr_set_s  = (start_s & txe_r) | (udr_pend_r & smp_s);

  // Pin synchronizers and one-cycle delayed copies for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      nss_sync_r  <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_d_r    <= 1'b0;
      nss_d_r     <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      nss_sync_r  <= {nss_sync_r[SYNC_STAGES-2:0], nss};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      sclk_d_r    <= sclk_s;
      nss_d_r     <= nss_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (nss_fall_s && spe_r) next_state_s = ACTIVE; else next_state_s = IDLE;
      ACTIVE:  if (nss_rise_s || !spe_r) next_state_s = IDLE; else next_state_s = ACTIVE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs: frame start from idle, or staying active.
  always_comb begin
    start_s = 1'b0;
    run_s   = 1'b0;
    case (state_r)
      IDLE:    if (next_state_s == ACTIVE) start_s = 1'b1; else start_s = 1'b0;
      ACTIVE:  if (next_state_s == ACTIVE) run_s = 1'b1; else run_s = 1'b0;
      default: begin start_s = 1'b0; run_s = 1'b0; end
    endcase
  end

  // Transmit shifter and miso/miso_oe pins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_sft_r  <= 16'h0000;
      miso_r    <= 1'b0;
      first_r   <= 1'b0;
      miso_oe_r <= 1'b0;
    end else begin
      miso_oe_r <= (next_state_s == ACTIVE);
      if (load_s) begin
        tx_sft_r <= tx_load_s;
        first_r  <= cpha_r;
        if (!cpha_r) miso_r <= pick_bit(tx_load_s, lsbf_r, dff_r);
      end else if (drv_s) begin
        first_r <= 1'b0;
        if (first_r) begin
          miso_r <= pick_bit(tx_sft_r, lsbf_r, dff_r);
        end else begin
          tx_sft_r <= tx_shift_s;
          miso_r   <= pick_bit(tx_shift_s, lsbf_r, dff_r);
        end
      end else if (next_state_s == IDLE) begin
        miso_r  <= 1'b0;
        first_r <= 1'b0;
      end
    end
  end

  // Receive shifter and bit counter; leaving ACTIVE drops the partial frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_sft_r  <= 16'h0000;
      bit_cnt_r <= 4'd0;
      done_r    <= 1'b0;
    end else if (run_s) begin
      if (smp_s) begin
        rx_sft_r <= rx_next_s;
        done_r   <= complete_s & ~cpha_r;
        if (complete_s) bit_cnt_r <= 4'd0;
        else            bit_cnt_r <= bit_cnt_r + 4'd1;
      end else if (b2b_s) begin
        done_r <= 1'b0;
      end
    end else begin
      bit_cnt_r <= 4'd0;
      done_r    <= 1'b0;
    end
  end

  // Control registers; frame format fields are frozen while SPE=1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      {cpha_r, cpol_r, spe_r, lsbf_r, dff_r} <= 5'b00000;
      {errie_r, rxneie_r, txeie_r}           <= 3'b000;
    end else begin
      if (cr1_wr_s) begin
        spe_r <= s_apb_intf.pwdata[6];
        if (!spe_r) begin
          cpha_r <= s_apb_intf.pwdata[0];
          cpol_r <= s_apb_intf.pwdata[1];
          lsbf_r <= s_apb_intf.pwdata[7];
          dff_r  <= s_apb_intf.pwdata[11];
        end
      end
      if (cr2_wr_s) begin
        errie_r  <= s_apb_intf.pwdata[5];
        rxneie_r <= s_apb_intf.pwdata[6];
        txeie_r  <= s_apb_intf.pwdata[7];
      end
    end
  end

  // Status flags and data buffers. An underrun on a back-to-back reload is held
  // pending until the next frame really starts sampling.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      txe_r      <= 1'b1;
      rxne_r     <= 1'b0;
      udr_r      <= 1'b0;
      ovr_r      <= 1'b0;
      udr_pend_r <= 1'b0;
      tx_buff_r  <= 16'h0000;
      rx_buff_r  <= 16'h0000;
    end else begin
      if (dr_wr_s) begin
        tx_buff_r <= s_apb_intf.pwdata[15:0];
        txe_r     <= 1'b0;
      end else if (load_s && !txe_r) begin
        txe_r <= 1'b1;
      end
      if (rx_store_s) begin
        rx_buff_r <= rx_word_s;
        rxne_r    <= 1'b1;
      end else if (dr_rd_s) begin
        rxne_r <= 1'b0;
      end
      if (!run_s)              udr_pend_r <= 1'b0;
      else if (b2b_s && txe_r) udr_pend_r <= 1'b1;
      else if (smp_s)          udr_pend_r <= 1'b0;
      if (udr_set_s)                             udr_r <= 1'b1;
      else if (sr_wr_s && !s_apb_intf.pwdata[3]) udr_r <= 1'b0;
      if (ovr_set_s)                             ovr_r <= 1'b1;
      else if (sr_wr_s && !s_apb_intf.pwdata[6]) ovr_r <= 1'b0;
    end
  end

  // Registered APB read data; zero whenever no read is being set up.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prdata_r <= 32'h0000_0000;
    end else if (rd_s) begin
      case (s_apb_intf.paddr)
        12'h000: prdata_r <= {20'h00000, dff_r, 3'b000, lsbf_r, spe_r, 4'b0000, cpol_r, cpha_r};
        12'h004: prdata_r <= {24'h000000, txeie_r, rxneie_r, errie_r, 5'b00000};
        12'h008: prdata_r <= {24'h000000, bsy_s, ovr_r, 2'b00, udr_r, 1'b0, rxne_r, txe_r};
        12'h00C: prdata_r <= {16'h0000, rx_buff_r};
        default: prdata_r <= 32'h0000_0000;
      endcase
    end else begin
      prdata_r <= 32'h0000_0000;
    end
  end

  assign s_apb_intf.prdata  = prdata_r;
  assign s_apb_intf.pready  = 1'b1;
  assign s_apb_intf.pslverr = 1'b0;
  assign miso    = miso_r;
  assign miso_oe = miso_oe_r;
  assign irq_out = (txeie_r & txe_r) | (rxneie_r & rxne_r) | (errie_r & (ovr_r | udr_r));

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: APB register access plus a bit-banged SPI master.
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int HALF = 60;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sclk = 1'b0;
  logic nss = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe, irq_out;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] rd;
  logic [15:0] got;

  apb_intf apb();

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .s_apb_intf(apb.slave),
    .sclk(sclk), .nss(nss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = addr; apb.pwdata = data;
    @(posedge clk); #1; apb.penable = 1'b1;
    @(posedge clk); #1; apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = addr;
    @(posedge clk); #1; data = apb.prdata; apb.penable = 1'b1;
    @(posedge clk); #1; apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  // Master side: drives mosi per mode, captures miso just before each sample edge.
  task automatic spi_bits(input logic cpol, input logic cpha, input logic lsbf, input int nbits,
                          input int nsend, input logic [15:0] dout, output logic [15:0] din);
    int b;
    din = 16'h0000;
    for (int i = 0; i < nsend; i++) begin
      b = lsbf ? i : nbits - 1 - i;
      if (!cpha) begin
        mosi = dout[b]; #HALF; din[b] = miso; sclk = ~cpol; #HALF; sclk = cpol;
      end else begin
        sclk = ~cpol; mosi = dout[b]; #HALF; din[b] = miso; sclk = cpol; #HALF;
      end
    end
  endtask

  task automatic sel(input logic v);
    nss = v;
    #100;
  endtask

  initial begin
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = 12'h000; apb.pwdata = 32'h0;
    #22;
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_irq", {31'd0, irq_out}, 32'd0);
    @(negedge clk); rstn = 1'b1;
    apb_read(12'h008, rd); check("rst_sr", rd, 32'h01);
    apb_read(12'h000, rd); check("rst_cr1", rd, 32'h0);
    apb_read(12'h00C, rd); check("rst_dr", rd, 32'h0);
    apb_write(12'h010, 32'hFFFF);
    apb_read(12'h010, rd); check("unmapped", rd, 32'h0);
    check("prdata_idle", apb.prdata, 32'h0);

    // Mode 0, 8-bit, MSB first
    apb_write(12'h000, 32'h0040);
    apb_write(12'h00C, 32'h00A5);
    sel(1'b0);
    check("oe_active", {31'd0, miso_oe}, 32'd1);
    apb_read(12'h008, rd); check("sr_bsy", rd, 32'h81);
    spi_bits(1'b0, 1'b0, 1'b0, 8, 8, 16'h003C, got);
    sel(1'b1);
    check("m0_miso", {16'd0, got}, 32'h00A5);
    apb_read(12'h008, rd); check("m0_sr", rd, 32'h03);
    apb_read(12'h00C, rd); check("m0_dr", rd, 32'h3C);

    // Back-to-back frames: overrun and underrun
    apb_write(12'h00C, 32'h005A);
    sel(1'b0);
    spi_bits(1'b0, 1'b0, 1'b0, 8, 8, 16'h0011, got);
    check("b2b_miso1", {16'd0, got}, 32'h005A);
    spi_bits(1'b0, 1'b0, 1'b0, 8, 8, 16'h0022, got);
    check("b2b_miso2", {16'd0, got}, 32'h0000);
    sel(1'b1);
    apb_read(12'h008, rd); check("b2b_sr", rd, 32'h4B);
    apb_read(12'h00C, rd); check("b2b_dr", rd, 32'h11);
    apb_write(12'h008, 32'h0);
    apb_read(12'h008, rd); check("sr_clr", rd, 32'h01);

    // Mode 3, 16-bit, LSB first
    apb_write(12'h000, 32'h0000);
    sclk = 1'b1;
    apb_write(12'h000, 32'h0883);
    apb_write(12'h000, 32'h08C3);
    apb_read(12'h000, rd); check("m3_cr1", rd, 32'h08C3);
    apb_write(12'h00C, 32'h1234);
    sel(1'b0);
    spi_bits(1'b1, 1'b1, 1'b1, 16, 16, 16'hBEEF, got);
    sel(1'b1);
    check("m3_miso", {16'd0, got}, 32'h1234);
    apb_read(12'h00C, rd); check("m3_dr", rd, 32'hBEEF);
    apb_read(12'h008, rd); check("m3_sr", rd, 32'h01);

    // Mode 1: aborted frame then a clean one
    apb_write(12'h000, 32'h0000);
    sclk = 1'b0;
    apb_write(12'h000, 32'h0001);
    apb_write(12'h000, 32'h0041);
    apb_write(12'h00C, 32'h0081);
    sel(1'b0);
    spi_bits(1'b0, 1'b1, 1'b0, 8, 5, 16'h0000, got);
    sel(1'b1);
    check("abort_oe", {31'd0, miso_oe}, 32'd0);
    apb_read(12'h008, rd); check("abort_sr", rd, 32'h01);
    apb_write(12'h00C, 32'h00C3);
    sel(1'b0);
    spi_bits(1'b0, 1'b1, 1'b0, 8, 8, 16'h0096, got);
    sel(1'b1);
    check("m1_miso", {16'd0, got}, 32'h00C3);
    apb_read(12'h00C, rd); check("m1_dr", rd, 32'h96);

    // Interrupts
    apb_write(12'h004, 32'h0040);
    check("irq_off", {31'd0, irq_out}, 32'd0);
    apb_write(12'h00C, 32'h003C);
    sel(1'b0);
    spi_bits(1'b0, 1'b1, 1'b0, 8, 8, 16'h005A, got);
    sel(1'b1);
    check("irq_miso", {16'd0, got}, 32'h003C);
    check("irq_rxne", {31'd0, irq_out}, 32'd1);
    apb_read(12'h00C, rd); check("irq_dr", rd, 32'h5A);
    check("irq_clr", {31'd0, irq_out}, 32'd0);
    apb_write(12'h004, 32'h0080);
    check("irq_txe", {31'd0, irq_out}, 32'd1);

    // Reset in the middle of a frame
    apb_write(12'h00C, 32'h0077);
    sel(1'b0);
    spi_bits(1'b0, 1'b1, 1'b0, 8, 3, 16'h00FF, got);
    rstn = 1'b0;
    #1;
    check("mid_rst_oe", {31'd0, miso_oe}, 32'd0);
    check("mid_rst_miso", {31'd0, miso}, 32'd0);
    check("mid_rst_irq", {31'd0, irq_out}, 32'd0);
    #20;
    @(negedge clk); rstn = 1'b1;
    sel(1'b1);
    apb_read(12'h008, rd); check("mid_rst_sr", rd, 32'h01);
    apb_read(12'h000, rd); check("mid_rst_cr1", rd, 32'h0);
    apb_read(12'h004, rd); check("mid_rst_cr2", rd, 32'h0);
    apb_read(12'h00C, rd); check("mid_rst_dr", rd, 32'h0);
    apb_write(12'h000, 32'h0040);
    apb_write(12'h000, 32'h0841);
    apb_read(12'h000, rd); check("dff_locked", rd, 32'h0040);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
